// File: rtl/button_debouncer.sv
// Push-button debouncer: qualifies a synchronized level over STABLE_CYCLES+1 identical samples
// and emits a registered debounced level plus single-cycle press/release pulses.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic R,
  input  logic sig,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StLow,
    StRise,
    StHigh,
    StFall
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StLow: begin
        cnt_d = '0;
        if (sig) state_d = StRise;
      end
      StRise: begin
        // A reverted sample discards progress, even on the would-be qualifying edge.
        if (!sig) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StHigh;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        cnt_d = '0;
        if (!sig) state_d = StFall;
      end
      StFall: begin
        if (sig) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= StLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4; pulses expected on the 4th edge
// after the edge that first samples a new level.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic R   = 1'b1;
  logic sig = 1'b0;
  logic level, rise_pulse, fall_pulse;

  int total = 0;
  int bad   = 0;

  button_debouncer #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .R         (R),
    .sig       (sig),
    .level     (level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b1;
    tick();
    R = 1'b0;
  endtask

  task automatic test_reset();
    R   = 1'b1;
    sig = 1'b1;
    tick();
    tick();
    total++;
    if ({level, rise_pulse, fall_pulse} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000", {level, rise_pulse, fall_pulse});
    end
    R = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (rise_pulse !== (i == 4) || fall_pulse !== 1'b0 || level !== (i >= 4)) begin
        bad++;
        $display("FAIL reset_release edge%0d: got lvl=%b r=%b f=%b want lvl=%b r=%b f=0",
                 i, level, rise_pulse, fall_pulse, (i >= 4), (i == 4));
      end
    end
  endtask

  task automatic test_clean_press();
    sig = 1'b0;
    do_reset();
    tick();
    sig = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (rise_pulse !== (i == 4) || fall_pulse !== 1'b0 || level !== (i >= 4)) begin
        bad++;
        $display("FAIL press edge%0d: got lvl=%b r=%b f=%b want lvl=%b r=%b f=0",
                 i, level, rise_pulse, fall_pulse, (i >= 4), (i == 4));
      end
    end
    sig = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (fall_pulse !== (i == 4) || rise_pulse !== 1'b0 || level !== (i < 4)) begin
        bad++;
        $display("FAIL release edge%0d: got lvl=%b r=%b f=%b want lvl=%b r=0 f=%b",
                 i, level, rise_pulse, fall_pulse, (i < 4), (i == 4));
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      sig = pat[i];
      tick();
      total++;
      if ({level, rise_pulse, fall_pulse} !== 3'b000) begin
        bad++;
        $display("FAIL bounce edge%0d: got %b want 000", i, {level, rise_pulse, fall_pulse});
      end
    end
    sig = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (rise_pulse !== (i == 4) || fall_pulse !== 1'b0 || level !== (i >= 4)) begin
        bad++;
        $display("FAIL bounce_settle edge%0d: got lvl=%b r=%b f=%b want lvl=%b r=%b f=0",
                 i, level, rise_pulse, fall_pulse, (i >= 4), (i == 4));
      end
    end
    // Revert on the qualifying edge of a release: back to high, no pulse.
    for (int i = 0; i < 6; i++) begin
      sig = (i == 4);
      tick();
      total++;
      if (level !== 1'b1 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
        bad++;
        $display("FAIL last_edge_bounce edge%0d: got lvl=%b r=%b f=%b want lvl=1 r=0 f=0",
                 i, level, rise_pulse, fall_pulse);
      end
    end
  endtask

  task automatic test_glitch_train();
    sig = 1'b0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      sig = ((i % 3) == 0);
      tick();
      total++;
      if ({level, rise_pulse, fall_pulse} !== 3'b000) begin
        bad++;
        $display("FAIL glitch edge%0d: got %b want 000", i, {level, rise_pulse, fall_pulse});
      end
    end
    sig = 1'b0;
  endtask

  task automatic test_reset_mid_qualify();
    sig = 1'b0;
    do_reset();
    sig = 1'b1;
    tick();
    tick();
    tick();
    R = 1'b1;
    tick();
    total++;
    if ({level, rise_pulse, fall_pulse} !== 3'b000 || dut.cnt_q !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset: got %b cnt=%0d want 000 cnt=0",
               {level, rise_pulse, fall_pulse}, dut.cnt_q);
    end
    R = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (rise_pulse !== (i == 4) || fall_pulse !== 1'b0 || level !== (i >= 4)) begin
        bad++;
        $display("FAIL mid_requalify edge%0d: got lvl=%b r=%b f=%b want lvl=%b r=%b f=0",
                 i, level, rise_pulse, fall_pulse, (i >= 4), (i == 4));
      end
    end
  endtask

  task automatic test_hold_high();
    int rises;
    int falls;
    int odd;
    sig = 1'b0;
    do_reset();
    sig = 1'b1;
    rises = 0;
    falls = 0;
    odd   = 0;
    for (int i = 0; i < 105; i++) begin
      tick();
      if (rise_pulse) rises++;
      if (fall_pulse) falls++;
      if (i >= 4 && (level !== 1'b1 || dut.cnt_q !== 2'd0)) odd++;
    end
    total++;
    if (rises != 1 || falls != 0) begin
      bad++;
      $display("FAIL hold_pulses: got rises=%0d falls=%0d want 1 and 0", rises, falls);
    end
    total++;
    if (odd != 0) begin
      bad++;
      $display("FAIL hold_level_cnt: got %0d bad cycles want 0", odd);
    end
    // Reset while high: level drops without a fall pulse.
    R = 1'b1;
    tick();
    total++;
    if ({level, rise_pulse, fall_pulse} !== 3'b000) begin
      bad++;
      $display("FAIL reset_from_high: got %b want 000", {level, rise_pulse, fall_pulse});
    end
    R = 1'b0;
    sig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch_train();
    test_reset_mid_qualify();
    test_hold_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
